mult_result_accumulator: RTL and testbench

Downstream post-processing stage for the DSP38 multiplier slice when it runs with DSP_MODE "MULTIPLY" and no input or output registers. It consumes the 38-bit Z product stream under a valid/ready handshake and accumulates a programmable number of products per block. It then applies right shift, optional rounding and optional saturation, and presents one narrow result per block on a valid/ready output.

---
 rtl/mult_acc_pkg.sv | 29 ++
 rtl/mult_result_accumulator_round_shift_sat.sv | 56 +++++
 rtl/mult_result_accumulator.sv | 120 ++++++++++++
 tb/tb_mult_result_accumulator.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_acc_pkg.sv
// Shared widths, FSM encodings and result-range limits for the product accumulator.
package mult_acc_pkg;

    localparam int Z_WIDTH     = 38;
    localparam int ACC_WIDTH   = 48;
    localparam int OUT_WIDTH   = 20;
    localparam int LEN_WIDTH   = 8;
    localparam int SHIFT_WIDTH = 6;
    localparam int RND_WIDTH   = ACC_WIDTH + 1;

    localparam logic [1:0] ST_ACC  = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_OUT  = 2'd2;

    // Range limits expressed in the widened rounding domain
    localparam logic signed [RND_WIDTH-1:0] S_HI = 49'sd524287;
    localparam logic signed [RND_WIDTH-1:0] S_LO = -49'sd524288;
    localparam logic        [RND_WIDTH-1:0] U_HI = 49'd1048575;

    localparam logic [OUT_WIDTH-1:0] SAT_S_MAX = 20'h7FFFF;
    localparam logic [OUT_WIDTH-1:0] SAT_S_MIN = 20'h80000;
    localparam logic [OUT_WIDTH-1:0] SAT_U_MAX = 20'hFFFFF;

    function automatic logic [ACC_WIDTH-1:0] ext_z(input logic [Z_WIDTH-1:0] z,
                                                   input logic is_signed);
        return {{(ACC_WIDTH-Z_WIDTH){is_signed & z[Z_WIDTH-1]}}, z};
    endfunction

endpackage

// File: rtl/mult_result_accumulator_round_shift_sat.sv
// Combinational post-scaling of the block sum: optional round half-up, right shift,
// range check and optional clamp to the result width.
module round_shift_sat
    import mult_acc_pkg::*;
(
    input  logic [ACC_WIDTH-1:0]   acc,
    input  logic [SHIFT_WIDTH-1:0] shift,
    input  logic                   round,
    input  logic                   is_signed,
    input  logic                   saturate,
    output logic [OUT_WIDTH-1:0]   data,
    output logic                   ovf
);

    logic [RND_WIDTH-1:0] acc_ext;
    logic [RND_WIDTH-1:0] rnd_bias;
    logic [RND_WIDTH-1:0] rnd;
    logic [RND_WIDTH-1:0] shifted;
    logic                 too_high;
    logic                 too_low;

    always_comb begin
        acc_ext  = {is_signed & acc[ACC_WIDTH-1], acc};
        rnd_bias = '0;
        // Bias bit beyond the widened domain simply drops out
        if (round && (shift != '0)) begin
            rnd_bias = RND_WIDTH'(1) << (shift - 1'b1);
        end
        rnd = acc_ext + rnd_bias;

        if (is_signed) begin
            shifted = $signed(rnd) >>> shift;
        end else begin
            shifted = rnd >> shift;
        end

        if (is_signed) begin
            too_high = ($signed(shifted) > S_HI);
            too_low  = ($signed(shifted) < S_LO);
        end else begin
            too_high = (shifted > U_HI);
            too_low  = 1'b0;
        end
        ovf = too_high | too_low;

        data = shifted[OUT_WIDTH-1:0];
        if (saturate) begin
            if (too_high) begin
                data = is_signed ? SAT_S_MAX : SAT_U_MAX;
            end else if (too_low) begin
                data = SAT_S_MIN;
            end
        end
    end

endmodule

// File: rtl/mult_result_accumulator.sv
// Accumulates blocks of DSP products and emits one scaled, optionally clamped result per block.
//   state   | meaning
//   ST_ACC  | accepting product beats into the block sum
//   ST_CALC | one cycle: round/shift/saturate the sum into the output register
//   ST_OUT  | result presented, waiting for out_ready
module mult_result_accumulator
    import mult_acc_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   clear,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [Z_WIDTH-1:0]     in_z,
    input  logic                   cfg_signed,
    input  logic [LEN_WIDTH-1:0]   cfg_len,
    input  logic [SHIFT_WIDTH-1:0] cfg_shift,
    input  logic                   cfg_round,
    input  logic                   cfg_saturate,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [OUT_WIDTH-1:0]   out_data,
    output logic                   out_ovf,
    output logic                   busy
);

    logic [1:0]             state;
    logic [ACC_WIDTH-1:0]   acc;
    logic [LEN_WIDTH-1:0]   cnt;
    logic [LEN_WIDTH-1:0]   len_q;
    logic [SHIFT_WIDTH-1:0] shift_q;
    logic                   signed_q;
    logic                   round_q;
    logic                   saturate_q;

    logic                   beat;
    logic                   first_beat;
    logic                   beat_signed;
    logic [LEN_WIDTH-1:0]   beat_len;
    logic                   last_beat;
    logic [ACC_WIDTH-1:0]   z_ext;
    logic [OUT_WIDTH-1:0]   calc_data;
    logic                   calc_ovf;

    assign in_ready   = (state == ST_ACC);
    assign out_valid  = (state == ST_OUT);
    assign busy       = (state != ST_ACC) | (cnt != '0);
    assign beat       = in_valid & in_ready;
    assign first_beat = (cnt == '0);

    // The first beat of a block uses the live config; later beats use the latched copy
    assign beat_signed = first_beat ? cfg_signed : signed_q;
    assign beat_len    = first_beat ? cfg_len : len_q;
    assign last_beat   = (cnt == beat_len);
    assign z_ext       = ext_z(in_z, beat_signed);

    round_shift_sat u_round_shift_sat (
        .acc       (acc),
        .shift     (shift_q),
        .round     (round_q),
        .is_signed (signed_q),
        .saturate  (saturate_q),
        .data      (calc_data),
        .ovf       (calc_ovf)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_ACC;
            acc        <= '0;
            cnt        <= '0;
            len_q      <= '0;
            shift_q    <= '0;
            signed_q   <= 1'b0;
            round_q    <= 1'b0;
            saturate_q <= 1'b0;
            out_data   <= '0;
            out_ovf    <= 1'b0;
        end else if (clear) begin
            state <= ST_ACC;
            cnt   <= '0;
            acc   <= '0;
        end else begin
            case (state)
                ST_ACC: begin
                    if (beat) begin
                        if (first_beat) begin
                            signed_q   <= cfg_signed;
                            len_q      <= cfg_len;
                            shift_q    <= cfg_shift;
                            round_q    <= cfg_round;
                            saturate_q <= cfg_saturate;
                            acc        <= z_ext;
                        end else begin
                            acc <= acc + z_ext;
                        end
                        if (last_beat) begin
                            cnt   <= '0;
                            state <= ST_CALC;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                ST_CALC: begin
                    out_data <= calc_data;
                    out_ovf  <= calc_ovf;
                    state    <= ST_OUT;
                end
                ST_OUT: begin
                    if (out_ready) begin
                        state <= ST_ACC;
                    end
                end
                default: state <= ST_ACC;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_result_accumulator.sv
// Directed bench for mult_result_accumulator with hand-computed block results.
module tb_mult_result_accumulator;
    import mult_acc_pkg::*;

    logic                   clk = 1'b0;
    logic                   reset = 1'b0;
    logic                   clear = 1'b0;
    logic                   in_valid = 1'b0;
    logic                   in_ready;
    logic [Z_WIDTH-1:0]     in_z = '0;
    logic                   cfg_signed = 1'b0;
    logic [LEN_WIDTH-1:0]   cfg_len = '0;
    logic [SHIFT_WIDTH-1:0] cfg_shift = '0;
    logic                   cfg_round = 1'b0;
    logic                   cfg_saturate = 1'b0;
    logic                   out_valid;
    logic                   out_ready = 1'b0;
    logic [OUT_WIDTH-1:0]   out_data;
    logic                   out_ovf;
    logic                   busy;

    int tests = 0;
    int fails = 0;
    logic [Z_WIDTH-1:0] beats [0:7];

    mult_result_accumulator dut (
        .clk          (clk),
        .reset        (reset),
        .clear        (clear),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_z         (in_z),
        .cfg_signed   (cfg_signed),
        .cfg_len      (cfg_len),
        .cfg_shift    (cfg_shift),
        .cfg_round    (cfg_round),
        .cfg_saturate (cfg_saturate),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_ovf      (out_ovf),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Sends n beats back to back, scrambling the config after the first one.
    task automatic run_block(input string name, input int n, input logic [5:0] sh,
                             input logic s, input logic rnd, input logic sat,
                             input logic [19:0] exp_d, input logic exp_o,
                             input logic handshake);
        cfg_signed   = s;
        cfg_len      = 8'(n - 1);
        cfg_shift    = sh;
        cfg_round    = rnd;
        cfg_saturate = sat;
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_z     = beats[i];
            step();
            if (i == 0) begin
                cfg_signed   = ~s;
                cfg_len      = ~cfg_len;
                cfg_shift    = ~sh;
                cfg_round    = ~rnd;
                cfg_saturate = ~sat;
            end
        end
        in_valid = 1'b0;
        in_z     = 'x;
        tests++;
        if (out_valid !== 1'b0 || busy !== 1'b1) begin
            fails++;
            $display("FAIL %s calc_cycle: out_valid=%b busy=%b, want 0 1", name, out_valid, busy);
        end
        step();
        tests++;
        if (out_valid !== 1'b1) begin
            fails++;
            $display("FAIL %s out_valid: got %b, want 1", name, out_valid);
        end
        tests++;
        if (out_data !== exp_d) begin
            fails++;
            $display("FAIL %s out_data: got %h, want %h", name, out_data, exp_d);
        end
        tests++;
        if (out_ovf !== exp_o) begin
            fails++;
            $display("FAIL %s out_ovf: got %b, want %b", name, out_ovf, exp_o);
        end
        if (handshake) begin
            out_ready = 1'b1;
            step();
            out_ready = 1'b0;
            tests++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
                fails++;
                $display("FAIL %s release: out_valid=%b in_ready=%b busy=%b, want 0 1 0",
                         name, out_valid, in_ready, busy);
            end
        end
    endtask

    task automatic test_reset();
        #1;
        tests++;
        if (out_valid !== 1'b0 || out_data !== 20'h0 || out_ovf !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL reset_outputs: valid=%b data=%h ovf=%b busy=%b, want 0 0 0 0",
                     out_valid, out_data, out_ovf, busy);
        end
        step();
        step();
        #3;
        reset = 1'b1;
        step();
        tests++;
        if (in_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_in_ready: got %b, want 1", in_ready);
        end
    endtask

    task automatic test_accumulate();
        beats[0] = 38'd5;
        beats[1] = -38'sd3;
        beats[2] = 38'd10;
        beats[3] = 38'd2;
        run_block("sum4_signed", 4, 6'd0, 1'b1, 1'b0, 1'b0, 20'd14, 1'b0, 1'b1);
    endtask

    task automatic test_round();
        beats[0] = 38'd24;
        run_block("round_up", 1, 6'd4, 1'b1, 1'b1, 1'b0, 20'd2, 1'b0, 1'b1);
        run_block("no_round", 1, 6'd4, 1'b1, 1'b0, 1'b0, 20'd1, 1'b0, 1'b1);
        beats[0] = -38'sd24;
        run_block("round_neg", 1, 6'd4, 1'b1, 1'b1, 1'b0, 20'hFFFFF, 1'b0, 1'b1);
        run_block("shift63_neg", 1, 6'd63, 1'b1, 1'b0, 1'b0, 20'hFFFFF, 1'b0, 1'b1);
    endtask

    task automatic test_saturate();
        beats[0] = 38'd600000;
        run_block("sat_pos", 1, 6'd0, 1'b1, 1'b0, 1'b1, 20'd524287, 1'b1, 1'b1);
        run_block("wrap_pos", 1, 6'd0, 1'b1, 1'b0, 1'b0, 20'd600000, 1'b1, 1'b1);
        beats[0] = -38'sd600000;
        run_block("sat_neg", 1, 6'd0, 1'b1, 1'b0, 1'b1, 20'h80000, 1'b1, 1'b1);
    endtask

    task automatic test_unsigned();
        beats[0] = 38'h3F_FFFF_FFFF;
        beats[1] = 38'h3F_FFFF_FFFF;
        // Sum is 2^39-2: >>20 -> 2^19-1, >>18 -> 2^21-1, >>38 -> 1
        run_block("uns_sh20", 2, 6'd20, 1'b0, 1'b0, 1'b1, 20'h7FFFF, 1'b0, 1'b1);
        run_block("uns_sh18_sat", 2, 6'd18, 1'b0, 1'b0, 1'b1, 20'hFFFFF, 1'b1, 1'b1);
        run_block("uns_sh38", 2, 6'd38, 1'b0, 1'b0, 1'b1, 20'd1, 1'b0, 1'b1);
        run_block("uns_sh63", 2, 6'd63, 1'b0, 1'b0, 1'b0, 20'd0, 1'b0, 1'b1);
    endtask

    task automatic test_backpressure();
        int bad = 0;
        beats[0] = 38'd100;
        run_block("bp_first", 1, 6'd0, 1'b1, 1'b0, 1'b0, 20'd100, 1'b0, 1'b0);
        in_valid = 1'b1;
        in_z     = 38'd999;
        for (int i = 0; i < 10; i++) begin
            step();
            if (out_valid !== 1'b1 || out_data !== 20'd100 || in_ready !== 1'b0) bad++;
        end
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL backpressure_hold: %0d bad cycles, want 0", bad);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        beats[0] = 38'd3;
        beats[1] = 38'd4;
        run_block("bp_fresh", 2, 6'd0, 1'b1, 1'b0, 1'b0, 20'd7, 1'b0, 1'b1);
    endtask

    task automatic test_abort();
        cfg_signed = 1'b1;
        cfg_len    = 8'd3;
        cfg_shift  = 6'd0;
        cfg_round  = 1'b0;
        cfg_saturate = 1'b0;
        in_valid = 1'b1;
        in_z = 38'd11;
        step();
        in_z = 38'd22;
        step();
        clear = 1'b1;
        in_z  = 38'd50;
        step();
        clear    = 1'b0;
        in_valid = 1'b0;
        tests++;
        if (busy !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
            fails++;
            $display("FAIL clear_state: busy=%b in_ready=%b out_valid=%b, want 0 1 0",
                     busy, in_ready, out_valid);
        end
        beats[0] = 38'd7;
        run_block("after_clear", 1, 6'd0, 1'b1, 1'b0, 1'b0, 20'd7, 1'b0, 1'b1);

        beats[0] = 38'd9;
        run_block("pre_reset", 1, 6'd0, 1'b1, 1'b0, 1'b0, 20'd9, 1'b0, 1'b0);
        #2;
        reset = 1'b0;
        #1;
        tests++;
        if (out_valid !== 1'b0 || out_data !== 20'd0 || out_ovf !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL async_reset: valid=%b data=%h ovf=%b busy=%b, want 0 0 0 0",
                     out_valid, out_data, out_ovf, busy);
        end
        #2;
        reset = 1'b1;
        step();
        tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            fails++;
            $display("FAIL post_reset: in_ready=%b out_valid=%b, want 1 0", in_ready, out_valid);
        end
        beats[0] = 38'd3;
        run_block("post_reset_blk", 1, 6'd0, 1'b1, 1'b0, 1'b0, 20'd3, 1'b0, 1'b1);
    endtask

    initial begin
        test_reset();
        test_accumulate();
        test_round();
        test_saturate();
        test_unsigned();
        test_backpressure();
        test_abort();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
